// File: rtl/vector_load_sequencer.sv
// vector_load_sequencer: streams (a,b) pairs into the input memories, zero-pads short batches,
// fires start_reading and waits for both reader and writer completion before loading again.
module vector_load_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int DEPTH        = VECTOR_WIDTH * DATA_WIDTH,
  parameter int ADDR_WIDTH   = 5,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data_a,
  input  logic [DATA_WIDTH-1:0] s_data_b,
  input  logic                  s_last,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  start_reading,
  input  logic                  reading_done,
  input  logic                  writer_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  batch_count
);
  localparam logic [2:0] LOAD = 3'd0, PAD = 3'd1, DRAIN = 3'd2, FIRE = 3'd3, WAIT = 3'd4;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  logic [2:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] da_q, da_d, db_q, db_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic we_q, we_d, rd_prev_q, wr_prev_q, rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
  logic hs, rd_edge, wr_edge;
  assign s_ready       = rst_n & (state_q == LOAD);
  assign busy          = state_q != LOAD;
  assign start_reading = state_q == FIRE;
  assign write_en      = we_q;
  assign write_addr    = waddr_q;
  assign data_a        = da_q;
  assign data_b        = db_q;
  assign batch_count   = cnt_q;
  always_comb begin
    hs        = s_valid & s_ready;
    rd_edge   = reading_done & ~rd_prev_q;
    wr_edge   = writer_done & ~wr_prev_q;
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    da_d      = da_q;
    db_d      = db_q;
    rd_seen_d = rd_seen_q;
    wr_seen_d = wr_seen_q;
    cnt_d     = cnt_q;
    case (state_q)
      LOAD: if (hs) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        da_d    = s_data_a;
        db_d    = s_data_b;
        addr_d  = addr_q + 1'b1;
        state_d = (addr_q == LAST) ? DRAIN : (s_last ? PAD : LOAD);
      end
      PAD: begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        da_d    = '0;
        db_d    = '0;
        addr_d  = addr_q + 1'b1;
        state_d = (addr_q == LAST) ? DRAIN : PAD;
      end
      DRAIN: state_d = FIRE;
      FIRE: begin
        rd_seen_d = 1'b0;
        wr_seen_d = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        // an edge arriving this cycle counts toward the exit condition
        rd_seen_d = rd_seen_q | rd_edge;
        wr_seen_d = wr_seen_q | wr_edge;
        if (rd_seen_d & wr_seen_d) begin
          state_d = LOAD;
          addr_d  = '0;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      addr_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      da_q      <= '0;
      db_q      <= '0;
      cnt_q     <= '0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      da_q      <= da_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      rd_prev_q <= reading_done;
      wr_prev_q <= writer_done;
      rd_seen_q <= rd_seen_d;
      wr_seen_q <= wr_seen_d;
    end
  end
endmodule

// File: tb/tb_vector_load_sequencer.sv
// tb_vector_load_sequencer: directed checks of loading, padding, done handshake, reset abort and counter wrap.
module tb_vector_load_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, reading_done = 1'b0, writer_done = 1'b0;
  logic [7:0] s_data_a = '0, s_data_b = '0, data_a, data_b, batch_count;
  logic [4:0] write_addr;
  logic s_ready, write_en, start_reading, busy;
  int cyc = 0, passed = 0, total = 0;
  logic [7:0] wa_q[$], a_q[$], b_q[$];
  int w_cyc[$], hs_cyc[$], sr_cyc[$];
  vector_load_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data_a(s_data_a),
    .s_data_b(s_data_b), .s_last(s_last), .write_en(write_en), .write_addr(write_addr),
    .data_a(data_a), .data_b(data_b), .start_reading(start_reading), .reading_done(reading_done),
    .writer_done(writer_done), .busy(busy), .batch_count(batch_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n) begin
    if (write_en) begin
      wa_q.push_back({3'b0, write_addr});
      a_q.push_back(data_a);
      b_q.push_back(data_b);
      w_cyc.push_back(cyc);
    end
    if (start_reading) sr_cyc.push_back(cyc);
    if (s_valid && s_ready) hs_cyc.push_back(cyc);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clr();
    wa_q.delete(); a_q.delete(); b_q.delete(); w_cyc.delete(); hs_cyc.delete(); sr_cyc.delete();
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1; s_data_a = a; s_data_b = b; s_last = l;
    for (int k = 0; k < 200 && !ok; k++) begin
      ok = s_ready;
      step();
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask
  task automatic wait_fire();
    int k;
    k = 0;
    while (!start_reading && k < 100) begin
      step();
      k++;
    end
    if (!start_reading) chk("fire_timeout", 0, 1);
    step();
  endtask
  task automatic done_both();
    reading_done = 1'b1; writer_done = 1'b1;
    step();
    reading_done = 1'b0; writer_done = 1'b0;
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_we"}, write_en, 0);
    chk({tag, "_addr"}, write_addr, 0);
    chk({tag, "_da"}, data_a, 0);
    chk({tag, "_db"}, data_b, 0);
    chk({tag, "_sr"}, start_reading, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, batch_count, 0);
  endtask
  initial begin
    int n, bad;
    #3;
    chk_reset_outs("rst");
    step(2);
    #2 rst_n = 1'b1;
    #1;
    chk("rel_ready", s_ready, 1);
    step();
    // full batch, back-to-back
    clr();
    for (int i = 0; i < 32; i++) send(8'(i), 8'(2 * i), 1'b0);
    s_valid = 1'b0;
    step(4);
    chk("full_nw", wa_q.size(), 32);
    chk("full_nhs", hs_cyc.size(), 32);
    for (int i = 0; i < 32 && i < wa_q.size() && i < hs_cyc.size(); i++) begin
      chk("full_addr", wa_q[i], i);
      chk("full_a", a_q[i], i);
      chk("full_b", b_q[i], 2 * i);
      chk("full_lat", w_cyc[i], hs_cyc[i] + 1);
    end
    chk("full_nsr", sr_cyc.size(), 1);
    if (sr_cyc.size() > 0 && hs_cyc.size() == 32) chk("full_sr_cyc", sr_cyc[0], hs_cyc[31] + 2);
    chk("full_wait_ready", s_ready, 0);
    chk("full_wait_busy", busy, 1);
    // writer edge 3 cycles before reader edge
    writer_done = 1'b1;
    step(3);
    chk("ord_hold", s_ready, 0);
    reading_done = 1'b1;
    chk("ord_pre", s_ready, 0);
    step();
    chk("ord_exit", s_ready, 1);
    chk("ord_cnt", batch_count, 1);
    // short batch, done levels stuck high from previous batch
    clr();
    for (int i = 0; i < 5; i++) send(8'(10 + i), 8'(20 + i), i == 4);
    s_valid = 1'b0; s_last = 1'b0;
    step(36);
    chk("short_nw", wa_q.size(), 32);
    for (int i = 0; i < 32 && i < wa_q.size(); i++) begin
      chk("short_addr", wa_q[i], i);
      chk("short_a", a_q[i], i < 5 ? 10 + i : 0);
      chk("short_b", b_q[i], i < 5 ? 20 + i : 0);
      chk("short_cyc", w_cyc[i], w_cyc[0] + i);
    end
    chk("short_nsr", sr_cyc.size(), 1);
    if (sr_cyc.size() > 0 && w_cyc.size() == 32) chk("short_sr_cyc", sr_cyc[0], w_cyc[31] + 1);
    chk("stuck_busy", busy, 1);
    chk("stuck_cnt", batch_count, 1);
    reading_done = 1'b0; writer_done = 1'b0;
    step();
    chk("stuck_busy2", busy, 1);
    done_both();
    chk("same_exit", s_ready, 1);
    chk("same_cnt", batch_count, 2);
    // alternating s_valid
    clr();
    n = 0;
    for (int c = 0; c < 64; c++) begin
      s_valid = (c % 2) == 0;
      s_data_a = 8'(n); s_data_b = ~8'(n);
      if (s_valid && s_ready) n++;
      step();
    end
    s_valid = 1'b0;
    step(3);
    chk("gap_nw", wa_q.size(), 32);
    for (int i = 0; i < 32 && i < wa_q.size(); i++) begin
      chk("gap_addr", wa_q[i], i);
      chk("gap_a", a_q[i], i);
    end
    chk("gap_nsr", sr_cyc.size(), 1);
    done_both();
    chk("gap_cnt", batch_count, 3);
    // reset mid-batch
    for (int i = 0; i < 10; i++) send(8'(i + 1), 8'(i + 1), 1'b0);
    s_valid = 1'b0;
    clr();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    step(2);
    #2 rst_n = 1'b1;
    step(40);
    chk("mid_nsr", sr_cyc.size(), 0);
    chk("mid_nw", wa_q.size(), 0);
    chk("mid_ready", s_ready, 1);
    send(8'h55, 8'h66, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    step(2);
    chk("mid_first_addr", wa_q.size() > 0 ? wa_q[0] : 8'hff, 0);
    chk("mid_first_a", a_q.size() > 0 ? a_q[0] : 8'h0, 8'h55);
    wait_fire();
    done_both();
    chk("mid_cnt", batch_count, 1);
    // wrap the batch counter
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      send(8'(i), 8'(i), 1'b1);
      s_valid = 1'b0;
      if (!busy) bad++;
      wait_fire();
      if (!busy || s_ready) bad++;
      done_both();
      if (busy || !s_ready) bad++;
      if (i == 253) chk("wrap_255", batch_count, 255);
    end
    chk("wrap_busy", bad, 0);
    chk("wrap_0", batch_count, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
